// File: rtl/simon_pkg.sv
// Shared constants and types for the SIMON32/64 encrypt core.
package simon_pkg;

    localparam int unsigned WORD   = 16;
    localparam int unsigned ROUNDS = 32;

    // z0 written in its published order: the leftmost digit belongs to round 0.
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

    localparam logic [WORD-1:0] C = 16'hFFFC;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    // z0 bit consumed by the key update of round rnd.
    function automatic logic z0_bit(input logic [4:0] rnd);
        logic [5:0] idx;
        idx = 6'd61 - {1'b0, rnd};
        return Z0[idx];
    endfunction

endpackage

// File: rtl/simon_encrypt_core_if.sv
// Plaintext/key request and ciphertext response handshakes of the encrypt core.
interface simon_encrypt_core_if;
    import simon_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [2*WORD-1:0] plaintext;
    logic [4*WORD-1:0] key;
    logic              out_valid;
    logic              out_ready;
    logic [2*WORD-1:0] ciphertext;
    logic              busy;

    modport master (
        output in_valid, plaintext, key, out_ready,
        input  in_ready, out_valid, ciphertext, busy
    );

    modport slave (
        input  in_valid, plaintext, key, out_ready,
        output in_ready, out_valid, ciphertext, busy
    );

endinterface

// File: rtl/simon_encrypt_round.sv
// One SIMON32/64 round plus the matching on-the-fly key schedule step.
module simon_encrypt_round
    import simon_pkg::*;
(
    input  logic [WORD-1:0] x,
    input  logic [WORD-1:0] y,
    input  logic [WORD-1:0] kw0,
    input  logic [WORD-1:0] kw1,
    input  logic [WORD-1:0] kw2,
    input  logic [WORD-1:0] kw3,
    input  logic [4:0]      rnd,
    output logic [WORD-1:0] x_next,
    output logic [WORD-1:0] y_next,
    output logic [WORD-1:0] k_new
);

    logic [WORD-1:0] f_x;
    logic [WORD-1:0] t_a;
    logic [WORD-1:0] t_b;

    // Round function on the current words, keyed by the oldest window entry.
    always_comb begin
        f_x    = ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]};
        x_next = y ^ f_x ^ kw0;
        y_next = x;
    end

    // Next round key, computed alongside the round that consumes kw0.
    always_comb begin
        t_a   = {kw3[2:0], kw3[15:3]} ^ kw1;
        t_b   = t_a ^ {t_a[0], t_a[15:1]};
        k_new = C ^ {{(WORD-1){1'b0}}, z0_bit(rnd)} ^ kw0 ^ t_b;
    end

    // kw2 only ages through the window; it is not mixed into this round.
    logic unused_kw2;
    assign unused_kw2 = ^kw2;

endmodule

// File: rtl/simon_encrypt_core.sv
// Iterative SIMON32/64 encryption: one round per clock, key expanded on the fly.
module simon_encrypt_core
    import simon_pkg::*;
(
    input logic                clk,
    input logic                rst,
    simon_encrypt_core_if.slave bus
);

    state_e          state_q;
    logic [WORD-1:0] x_q;
    logic [WORD-1:0] y_q;
    logic [WORD-1:0] kw_q [4];
    logic [4:0]      rnd_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;

    logic [WORD-1:0] x_next;
    logic [WORD-1:0] y_next;
    logic [WORD-1:0] k_new;

    simon_encrypt_round u_round (
        .x      (x_q),
        .y      (y_q),
        .kw0    (kw_q[0]),
        .kw1    (kw_q[1]),
        .kw2    (kw_q[2]),
        .kw3    (kw_q[3]),
        .rnd    (rnd_q),
        .x_next (x_next),
        .y_next (y_next),
        .k_new  (k_new)
    );

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            for (int i = 0; i < 4; i++) kw_q[i] <= '0;
            rnd_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_q <= bus.plaintext[2*WORD-1:WORD];
                        y_q <= bus.plaintext[WORD-1:0];
                        for (int i = 0; i < 4; i++) kw_q[i] <= bus.key[i*WORD +: WORD];
                        rnd_q      <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    x_q     <= x_next;
                    y_q     <= y_next;
                    kw_q[0] <= kw_q[1];
                    kw_q[1] <= kw_q[2];
                    kw_q[2] <= kw_q[3];
                    kw_q[3] <= k_new;
                    rnd_q   <= rnd_q + 5'd1;
                    if (rnd_q == 5'(ROUNDS - 1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // x/y stay frozen in DONE, so the ciphertext is stable while out_valid is high.
    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.ciphertext = {x_q, y_q};

endmodule

// File: tb/tb_simon_encrypt_core.sv
// Self-checking bench for simon_encrypt_core against a whole-block SIMON32/64 model.
module tb_simon_encrypt_core;

    typedef logic [31:0][15:0] sched_t;

    localparam logic [63:0] KAT_KEY = 64'h1918_1110_0908_0100;
    localparam logic [31:0] KAT_PT  = 32'h6565_6877;
    localparam logic [31:0] KAT_CT  = 32'hC69B_E9BB;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    simon_encrypt_core_if bus ();

    simon_encrypt_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rol(input logic [15:0] v, input int n);
        return (v << n) | (v >> (16 - n));
    endfunction

    function automatic logic [15:0] ror(input logic [15:0] v, input int n);
        return (v >> n) | (v << (16 - n));
    endfunction

    function automatic logic [15:0] f(input logic [15:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    // Full 32-entry key schedule, textbook form: k[i+4] = ~k[i] ^ tmp ^ z0[i] ^ 3.
    function automatic sched_t expand(input logic [63:0] key);
        sched_t      k;
        logic [15:0] tmp;
        logic [61:0] z;
        z = 62'b11111010001001010110000111001101111101000100101011000011100110;
        for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            tmp  = ror(k[i-1], 3) ^ k[i-3];
            tmp  = tmp ^ ror(tmp, 1);
            k[i] = ~k[i-4] ^ tmp ^ {15'b0, z[61-(i-4)]} ^ 16'd3;
        end
        return k;
    endfunction

    function automatic logic [31:0] ref_encrypt(input logic [31:0] pt, input logic [63:0] key);
        sched_t      k;
        logic [15:0] x, y, tmp;
        k = expand(key);
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            tmp = x;
            x   = y ^ f(x) ^ k[i];
            y   = tmp;
        end
        return {x, y};
    endfunction

    // Stands in for the decrypt core: inverse rounds with the same schedule.
    function automatic logic [31:0] ref_decrypt(input logic [31:0] ct, input logic [63:0] key);
        sched_t      k;
        logic [15:0] x, y, tmp;
        k = expand(key);
        x = ct[31:16];
        y = ct[15:0];
        for (int i = 31; i >= 0; i--) begin
            tmp = x;
            x   = y;
            y   = tmp ^ f(x) ^ k[i];
        end
        return {x, y};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one block from IDLE, waits (bounded) for out_valid, then completes the handshake.
    task automatic run_block(input logic [31:0] pt, input logic [63:0] key,
                             output logic [31:0] ct, output int lat);
        bus.plaintext = pt;
        bus.key       = key;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        if (!bus.out_valid) lat = -1;
        ct = bus.ciphertext;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready got %0b want 1", bus.in_ready);
        end
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid got %0b want 0", bus.out_valid);
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy got %0b want 0", bus.busy);
        end
        vectors++;
        if (bus.ciphertext !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_ciphertext got %h want 00000000", bus.ciphertext);
        end
    endtask

    task automatic test_known_answer();
        int  lat;
        bit  ready_seen;
        bus.out_ready = 1'b1;
        bus.plaintext = KAT_PT;
        bus.key       = KAT_KEY;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL kat_busy got %0b want 1", bus.busy);
        end
        lat        = 0;
        ready_seen = 1'b0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready !== 1'b0) ready_seen = 1'b1;
            bus.plaintext = $urandom;
            tick();
            lat++;
        end
        if (bus.in_ready !== 1'b0) ready_seen = 1'b1;
        vectors++;
        if (lat !== 32 || !bus.out_valid) begin
            miscompares++;
            $display("FAIL kat_latency got %0d want 32", lat);
        end
        vectors++;
        if (ready_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL kat_in_ready_low got high want low during run");
        end
        vectors++;
        if (bus.ciphertext !== KAT_CT) begin
            miscompares++;
            $display("FAIL kat_ciphertext got %h want %h", bus.ciphertext, KAT_CT);
        end
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL kat_return got out_valid=%0b in_ready=%0b want 0/1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_ct;
        int          lat;
        bit          stable;
        exp_ct        = ref_encrypt(KAT_PT, KAT_KEY);
        bus.out_ready = 1'b0;
        bus.plaintext = KAT_PT;
        bus.key       = KAT_KEY;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        vectors++;
        if (lat !== 32 || !bus.out_valid) begin
            miscompares++;
            $display("FAIL bp_latency got %0d want 32", lat);
        end
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.ciphertext !== exp_ct || bus.in_ready !== 1'b0)
                stable = 1'b0;
        end
        vectors++;
        if (stable !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_hold got ct=%h valid=%0b want %h/1", bus.ciphertext,
                     bus.out_valid, exp_ct);
        end
        bus.out_ready = 1'b1;
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release got out_valid=%0b in_ready=%0b want 0/1",
                     bus.out_valid, bus.in_ready);
        end
        tick();
        vectors++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_single_handshake got busy=%0b out_valid=%0b want 0/0",
                     bus.busy, bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int          cyc;
        int          lat;
        bit          seen_ready;
        logic [31:0] exp_b;
        exp_b         = ref_encrypt(32'h0, KAT_KEY);
        bus.out_ready = 1'b1;
        bus.plaintext = KAT_PT;
        bus.key       = KAT_KEY;
        bus.in_valid  = 1'b1;
        tick();
        cyc = 0;
        // Garbage on the inputs during RUN must not disturb the block in flight.
        while (!bus.out_valid && cyc < 100) begin
            bus.plaintext = $urandom;
            bus.key       = {$urandom, $urandom};
            tick();
            cyc++;
        end
        vectors++;
        if (bus.ciphertext !== KAT_CT) begin
            miscompares++;
            $display("FAIL b2b_first_ct got %h want %h", bus.ciphertext, KAT_CT);
        end
        bus.plaintext = 32'h0;
        bus.key       = KAT_KEY;
        seen_ready    = 1'b0;
        while (cyc < 100 && !(seen_ready && !bus.in_ready)) begin
            if (bus.in_ready) seen_ready = 1'b1;
            tick();
            cyc++;
        end
        vectors++;
        if (cyc !== 34) begin
            miscompares++;
            $display("FAIL b2b_period got %0d want 34", cyc);
        end
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        vectors++;
        if (bus.ciphertext !== exp_b || lat !== 32) begin
            miscompares++;
            $display("FAIL b2b_second_ct got %h lat %0d want %h lat 32", bus.ciphertext, lat,
                     exp_b);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] ct;
        int          lat;
        bus.out_ready = 1'b1;
        bus.plaintext = KAT_PT;
        bus.key       = KAT_KEY;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.ciphertext !== 32'h0 ||
            bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_state got rdy=%0b vld=%0b ct=%h busy=%0b want 1/0/0/0",
                     bus.in_ready, bus.out_valid, bus.ciphertext, bus.busy);
        end
        run_block(KAT_PT, KAT_KEY, ct, lat);
        vectors++;
        if (ct !== KAT_CT || lat !== 32) begin
            miscompares++;
            $display("FAIL midreset_rerun got %h lat %0d want %h lat 32", ct, lat, KAT_CT);
        end
    endtask

    task automatic test_round_trip();
        logic [31:0] pt, ct;
        logic [63:0] key;
        int          lat;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            pt  = $urandom;
            key = {$urandom, $urandom};
            run_block(pt, key, ct, lat);
            vectors++;
            if (ct !== ref_encrypt(pt, key) || lat !== 32) begin
                miscompares++;
                $display("FAIL rt_encrypt n=%0d got %h lat %0d want %h lat 32", n, ct, lat,
                         ref_encrypt(pt, key));
            end
            vectors++;
            if (ref_decrypt(ct, key) !== pt) begin
                miscompares++;
                $display("FAIL rt_decrypt n=%0d got %h want %h", n, ref_decrypt(ct, key), pt);
            end
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.plaintext = '0;
        bus.key       = '0;
        test_reset();
        test_known_answer();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_round_trip();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
